mpeg_gray_ptr_fifo: RTL and testbench

//  Single-clock FWFT FIFO for the MPEG data path, DEPTH = 2**DEPTH_LOG2 entries of WIDTH bits.

---
 rtl/mpeg_gray_ptr_fifo_pkg.sv | 20 ++
 rtl/mpeg_gray_ptr_fifo_b2g.sv | 12 +
 rtl/mpeg_gray_ptr_fifo.sv | 119 +++++++++++
 tb/tb_mpeg_gray_ptr_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_gray_ptr_fifo_pkg.sv
// Shared utilities for the MPEG Gray-pointer FIFO: byte reversal for
// big-endian stream words and small bit-mask / Gray helpers.
package mpeg_gray_ptr_fifo_pkg;

    // Reverse the byte order of a 32-bit word (big-endian <-> little-endian).
    function automatic logic [31:0] byte_reverse(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Mask with the n least significant bits set (n clipped to 32).
    function automatic logic [31:0] ones_mask(input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mpeg_gray_ptr_fifo_b2g.sv
// Binary to reflected-Gray converter used on the FIFO's next-pointer values.
module b2g_converter #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    // Adjacent binary values map to codes that differ in exactly one bit.
    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/mpeg_gray_ptr_fifo.sv
// Single-clock first-word-fall-through FIFO with registered Gray pointers
// exported for a downstream clock-domain-crossing stage.
//
// Handshake: a write happens on a cycle where wr_valid && wr_ready, a read
// on a cycle where rd_valid && rd_ready; neither side's ready/valid depends
// combinationally on the other side's valid/ready, and flush or reset in the
// same cycle cancels both transfers.
module mpeg_gray_ptr_fifo
    import mpeg_gray_ptr_fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int SWAP_BYTES = 0,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   wr_ptr_gray,
    output logic [DEPTH_LOG2:0]   rd_ptr_gray
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    // Reject parameter combinations the datapath cannot honour.
    if (SWAP_BYTES == 1 && WIDTH != 32) begin : g_bad_swap_width
        $error("mpeg_gray_ptr_fifo: SWAP_BYTES=1 requires WIDTH=32");
    end
    if (AF_MARGIN > DEPTH) begin : g_bad_af_margin
        $error("mpeg_gray_ptr_fifo: AF_MARGIN must not exceed DEPTH");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_gray;
    logic [PW-1:0]    r_rd_gray;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_clear;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [PW-1:0]    w_wr_gray_nxt;
    logic [PW-1:0]    w_rd_gray_nxt;
    logic [WIDTH-1:0] w_store_data;

    // Lap bit (MSB) separates "same slot, full" from "same slot, empty".
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    assign w_clear   = reset || flush;
    assign w_wr_fire = wr_valid && !w_full && !w_clear;
    assign w_rd_fire = rd_ready && !w_empty && !w_clear;

    assign w_wr_ptr_nxt = w_wr_fire ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_fire ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    // Gray codes are computed from the next pointer so the registered Gray
    // value changes in the same cycle as its binary pointer.
    b2g_converter #(.WIDTH(PW)) u_wr_b2g (
        .i_bin  (w_wr_ptr_nxt),
        .o_gray (w_wr_gray_nxt)
    );

    b2g_converter #(.WIDTH(PW)) u_rd_b2g (
        .i_bin  (w_rd_ptr_nxt),
        .o_gray (w_rd_gray_nxt)
    );

    if (SWAP_BYTES == 1) begin : g_swap
        assign w_store_data = WIDTH'(byte_reverse(32'(wr_data)));
    end else begin : g_noswap
        assign w_store_data = wr_data;
    end

    // Pointer and Gray pointer registers; reset and flush both return to 0.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wr_gray <= '0;
            r_rd_gray <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_wr_gray <= w_wr_gray_nxt;
            r_rd_gray <= w_rd_gray_nxt;
        end
    end

    // Storage array, left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[PW-2:0]] <= w_store_data;
        end
    end

    assign wr_ready    = !w_full;
    assign rd_valid    = !w_empty;
    assign rd_data     = r_mem[r_rd_ptr[PW-2:0]];
    assign level       = r_wr_ptr - r_rd_ptr;
    assign almost_full = (level >= AF_THRESH);
    assign wr_ptr_gray = r_wr_gray;
    assign rd_ptr_gray = r_rd_gray;

endmodule

// File: tb/tb_mpeg_gray_ptr_fifo.sv
// Bench for mpeg_gray_ptr_fifo: a 4-entry plain instance driven by directed
// and random traffic against a queue model, and a 16-entry byte-swapping
// instance checked for the reversed byte order.
module tb_mpeg_gray_ptr_fifo;

    localparam int W     = 32;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int PW    = 3;
    localparam int SDL2  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // ---------------- plain instance ----------------
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [W-1:0]  wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [W-1:0]  rd_data;
    logic [PW-1:0] level;
    logic          almost_full;
    logic [PW-1:0] wr_ptr_gray;
    logic [PW-1:0] rd_ptr_gray;

    mpeg_gray_ptr_fifo #(
        .WIDTH(W), .DEPTH_LOG2(DL2), .SWAP_BYTES(0), .AF_MARGIN(2)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .almost_full(almost_full),
        .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray)
    );

    // ---------------- byte-swap instance ----------------
    logic            sw_flush = 1'b0;
    logic            sw_wr_valid = 1'b0;
    logic            sw_wr_ready;
    logic [W-1:0]    sw_wr_data = '0;
    logic            sw_rd_valid;
    logic            sw_rd_ready = 1'b0;
    logic [W-1:0]    sw_rd_data;
    logic [SDL2:0]   sw_level;
    logic            sw_almost_full;
    logic [SDL2:0]   sw_wr_ptr_gray;
    logic [SDL2:0]   sw_rd_ptr_gray;

    mpeg_gray_ptr_fifo #(
        .WIDTH(W), .DEPTH_LOG2(SDL2), .SWAP_BYTES(1), .AF_MARGIN(2)
    ) dut_sw (
        .clk(clk), .reset(reset), .flush(sw_flush),
        .wr_valid(sw_wr_valid), .wr_ready(sw_wr_ready), .wr_data(sw_wr_data),
        .rd_valid(sw_rd_valid), .rd_ready(sw_rd_ready), .rd_data(sw_rd_data),
        .level(sw_level), .almost_full(sw_almost_full),
        .wr_ptr_gray(sw_wr_ptr_gray), .rd_ptr_gray(sw_rd_ptr_gray)
    );

    // ---------------- scoreboard / reference model ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sw_q[$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [PW-1:0] gray_tab [8];
    logic [PW-1:0] prev_wg = '0;
    logic [PW-1:0] prev_rg = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Compare every output of the plain instance with the queue model.
    task automatic check_all(input bit jumped);
        chk("level", W'(level), W'(exp_q.size()));
        chk("rd_valid", W'(rd_valid), W'(exp_q.size() != 0));
        chk("wr_ready", W'(wr_ready), W'(exp_q.size() < DEPTH));
        chk("almost_full", W'(almost_full), W'(exp_q.size() >= DEPTH - 2));
        chk("wr_ptr_gray", W'(wr_ptr_gray), W'(gray_tab[wr_cnt % 8]));
        chk("rd_ptr_gray", W'(rd_ptr_gray), W'(gray_tab[rd_cnt % 8]));
        if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q[0]);
        if (!jumped) begin
            chk("wr_gray_one_bit", W'($countones(prev_wg ^ wr_ptr_gray) <= 1), W'(1));
            chk("rd_gray_one_bit", W'($countones(prev_rg ^ rd_ptr_gray) <= 1), W'(1));
        end
        prev_wg = wr_ptr_gray;
        prev_rg = rd_ptr_gray;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit wv, input logic [W-1:0] wd, input bit rr, input bit fl);
        bit wf;
        bit rf;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        wf = wv && (exp_q.size() < DEPTH) && !fl;
        rf = rr && (exp_q.size() > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            if (rf) begin
                void'(exp_q.pop_front());
                rd_cnt++;
            end
            if (wf) begin
                exp_q.push_back(wd);
                wr_cnt++;
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        check_all(fl);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        exp_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        check_all(1'b1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] d;
        gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

        // Reset values
        do_reset();
        chk("rst_level", W'(level), W'(0));
        chk("rst_rd_valid", W'(rd_valid), W'(0));
        chk("rst_wr_ready", W'(wr_ready), W'(1));
        chk("rst_wr_gray", W'(wr_ptr_gray), W'(0));
        chk("rst_rd_gray", W'(rd_ptr_gray), W'(0));

        // First-word latency: nothing visible in the write cycle itself
        wr_valid = 1'b1;
        wr_data  = 32'h0000_00A5;
        #1;
        chk("a5_same_cycle_rd_valid", W'(rd_valid), W'(0));
        cycle(1'b1, 32'h0000_00A5, 1'b0, 1'b0);
        chk("a5_next_rd_valid", W'(rd_valid), W'(1));
        chk("a5_next_rd_data", rd_data, 32'h0000_00A5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("a5_drained", W'(rd_valid), W'(0));

        // Fill to full, stall, read while full, drain in order
        for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
        chk("full_wr_ready", W'(wr_ready), W'(0));
        chk("full_level", W'(level), W'(4));
        chk("full_almost_full", W'(almost_full), W'(1));
        cycle(1'b1, 32'h99, 1'b0, 1'b0);
        chk("full_stall_level", W'(level), W'(4));
        chk("order_1", rd_data, W'(1));
        cycle(1'b1, 32'h99, 1'b1, 1'b0);
        chk("after_full_read_level", W'(level), W'(3));
        chk("after_full_read_wr_ready", W'(wr_ready), W'(1));
        for (int i = 2; i <= 4; i++) begin
            chk("order_n", rd_data, W'(i));
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drained_rd_valid", W'(rd_valid), W'(0));

        // Streaming read+write: constant level, Gray pointers wrap through 0
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, $urandom, 1'b1, 1'b0);
            chk("stream_level", W'(level), W'(2));
        end

        // Flush with concurrent handshakes discards everything
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("flush_level", W'(level), W'(0));
        chk("flush_wr_gray", W'(wr_ptr_gray), W'(0));
        chk("flush_rd_gray", W'(rd_ptr_gray), W'(0));
        cycle(1'b1, 32'h5A5A_1234, 1'b0, 1'b0);
        chk("post_flush_data", rd_data, 32'h5A5A_1234);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Reset in the middle of traffic
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b1, 1'b0);
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        do_reset();
        chk("mid_reset_level", W'(level), W'(0));

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 39) == 0));
        end

        // Byte-swapping instance
        sw_wr_valid = 1'b1;
        sw_wr_data  = 32'h1122_3344;
        @(posedge clk);
        #1;
        sw_wr_valid = 1'b0;
        chk("swap_rd_valid", W'(sw_rd_valid), W'(1));
        chk("swap_rd_data", sw_rd_data, 32'h4433_2211);
        chk("swap_level", W'(sw_level), W'(1));
        chk("swap_wr_gray", W'(sw_wr_ptr_gray), W'(1));
        chk("swap_rd_gray", W'(sw_rd_ptr_gray), W'(0));
        chk("swap_af", W'(sw_almost_full), W'(0));
        chk("swap_wr_ready", W'(sw_wr_ready), W'(1));
        sw_rd_ready = 1'b1;
        @(posedge clk);
        #1;
        sw_rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            sw_q.push_back({d[7:0], d[15:8], d[23:16], d[31:24]});
            sw_wr_valid = 1'b1;
            sw_wr_data  = d;
            @(posedge clk);
            #1;
        end
        sw_wr_valid = 1'b0;
        while (sw_q.size() != 0) begin
            chk("swap_rand_data", sw_rd_data, sw_q.pop_front());
            sw_rd_ready = 1'b1;
            @(posedge clk);
            #1;
            sw_rd_ready = 1'b0;
        end
        chk("swap_drained", W'(sw_rd_valid), W'(0));

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
